// File: rtl/ram_arb_dx.sv
// ram_arb_dx: two-master arbiter for RAM port A with one-enabled-cycle read return.
// Define RAM_ARB_DX_RR_EN for round-robin arbitration; default build is fixed priority (master 0 wins).
module ram_arb_dx #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8
) (
  input  logic                AClkA,
  input  logic                AResetAN,
  input  logic                AClkAEn,
  input  logic [CAddrLen-1:0] AAddr0,
  input  logic [CAddrLen-1:0] AAddr1,
  input  logic [CDataLen-1:0] AMosi0,
  input  logic [CDataLen-1:0] AMosi1,
  input  logic                AWrEn0,
  input  logic                AWrEn1,
  input  logic                ARdEn0,
  input  logic                ARdEn1,
  output logic                AAck0,
  output logic                AAck1,
  output logic [CDataLen-1:0] AMiso0,
  output logic [CDataLen-1:0] AMiso1,
  output logic                AMisoVal0,
  output logic                AMisoVal1,
  output logic [CAddrLen-1:0] ARamAddr,
  output logic [CDataLen-1:0] ARamMosi,
  output logic                ARamWrEn,
  output logic                ARamRdEn,
  input  logic [CDataLen-1:0] ARamMiso
);
  logic act, req0, req1, gnt0, gnt1, pend, owner;
  // Everything combinational is gated by reset too, so all outputs read zero while held in reset.
  assign act  = AClkAEn & AResetAN;
  assign req0 = AWrEn0 | ARdEn0;
  assign req1 = AWrEn1 | ARdEn1;
`ifdef RAM_ARB_DX_RR_EN
  logic last;
  assign gnt0 = act & req0 & (~req1 | last);
`else
  assign gnt0 = act & req0;
`endif
  assign gnt1      = act & req1 & ~gnt0;
  assign AAck0     = gnt0;
  assign AAck1     = gnt1;
  assign ARamAddr  = gnt0 ? AAddr0 : gnt1 ? AAddr1 : '0;
  assign ARamMosi  = gnt0 ? AMosi0 : gnt1 ? AMosi1 : '0;
  assign ARamWrEn  = (gnt0 & AWrEn0) | (gnt1 & AWrEn1);
  assign ARamRdEn  = (gnt0 & ~AWrEn0 & ARdEn0) | (gnt1 & ~AWrEn1 & ARdEn1);
  assign AMisoVal0 = act & pend & ~owner;
  assign AMisoVal1 = act & pend & owner;
  assign AMiso0    = AMisoVal0 ? ARamMiso : '0;
  assign AMiso1    = AMisoVal1 ? ARamMiso : '0;
  always_ff @(posedge AClkA or negedge AResetAN)
    if (!AResetAN) begin
      pend  <= 1'b0;
      owner <= 1'b0;
`ifdef RAM_ARB_DX_RR_EN
      last  <= 1'b1;
`endif
    end else if (AClkAEn) begin
      pend <= ARamRdEn;
      if (ARamRdEn) owner <= gnt1;
`ifdef RAM_ARB_DX_RR_EN
      if (gnt0 | gnt1) last <= gnt1;
`endif
    end
endmodule
